// File: rtl/tick_gen_multi.sv
// Multi-channel programmable tick generator: per-channel divisor, tick pulse
// and 50% square wave, with one channel muxed onto a shared output pair.
module tick_gen_multi #(
    parameter int               NUM_CH      = 4,
    parameter int               CNT_W       = 32,
    parameter int               SEL_W       = 2,
    parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(50_000_000)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              wr_en,
    input  logic [SEL_W-1:0]  wr_ch,
    input  logic [CNT_W-1:0]  wr_div,
    input  logic              sync,
    input  logic [SEL_W-1:0]  sel,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] square,
    output logic              tick_sel,
    output logic              square_sel
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0] r_div;
        logic [CNT_W-1:0] r_cnt;
        logic             r_tick;
        logic             r_sq;
        logic             w_wr;
        logic             w_term;

        // Out-of-range write indices match no channel and are dropped.
        assign w_wr   = wr_en && (wr_ch == SEL_W'(g));
        assign w_term = (r_cnt == r_div);

        always_ff @(posedge clk) begin
            if (!rst) begin
                r_div  <= DEFAULT_DIV;
                r_cnt  <= '0;
                r_tick <= 1'b0;
                r_sq   <= 1'b0;
            end else if (sync) begin
                r_cnt  <= '0;
                r_tick <= 1'b0;
                r_sq   <= 1'b0;
            end else if (w_wr) begin
                r_div  <= wr_div;
                r_cnt  <= '0;
                r_tick <= 1'b0;
            end else if (en[g]) begin
                // Wrap via the terminal compare, so D = all-ones never overflows.
                r_cnt  <= w_term ? '0 : r_cnt + CNT_W'(1);
                r_tick <= w_term;
                if (w_term) begin
                    r_sq <= ~r_sq;
                end
            end else begin
                r_tick <= 1'b0;
            end
        end

        assign tick[g]   = r_tick;
        assign square[g] = r_sq;
    end

    logic w_tick_sel;
    logic w_sq_sel;

    always_comb begin
        w_tick_sel = 1'b0;
        w_sq_sel   = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel == SEL_W'(i)) begin
                w_tick_sel = tick[i];
                w_sq_sel   = square[i];
            end
        end
    end

    assign tick_sel   = w_tick_sel;
    assign square_sel = w_sq_sel;

endmodule

// File: tb/tb_tick_gen_multi.sv
// Bench for tick_gen_multi: period-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_tick_gen_multi;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;
    localparam int SEL_W  = 3;
    localparam logic [CNT_W-1:0] DEF = 8'd4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NUM_CH-1:0] en = '0;
    logic              wr_en = 1'b0;
    logic [SEL_W-1:0]  wr_ch = '0;
    logic [CNT_W-1:0]  wr_div = '0;
    logic              sync = 1'b0;
    logic [SEL_W-1:0]  sel = '0;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] square;
    logic              tick_sel;
    logic              square_sel;

    tick_gen_multi #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .SEL_W(SEL_W), .DEFAULT_DIV(DEF)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_ch(wr_ch),
        .wr_div(wr_div), .sync(sync), .sel(sel), .tick(tick),
        .square(square), .tick_sel(tick_sel), .square_sel(square_sel)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    // Model: enabled edges since last restart, divisor, square phase at restart.
    int               m_n    [NUM_CH];
    logic [CNT_W-1:0] m_div  [NUM_CH];
    bit               m_base [NUM_CH];
    bit               m_tick [NUM_CH];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic bit m_sq(int i);
        int p;
        p = int'(m_div[i]) + 1;
        return m_base[i] ^ (((m_n[i] / p) % 2) == 1);
    endfunction

    task automatic model_edge();
        for (int i = 0; i < NUM_CH; i++) begin
            if (!rst) begin
                m_div[i] = DEF; m_n[i] = 0; m_base[i] = 0; m_tick[i] = 0;
            end else if (sync) begin
                m_n[i] = 0; m_base[i] = 0; m_tick[i] = 0;
            end else if (wr_en && int'(wr_ch) == i) begin
                m_base[i] = m_sq(i);
                m_div[i] = wr_div; m_n[i] = 0; m_tick[i] = 0;
            end else if (en[i]) begin
                m_n[i]++;
                m_tick[i] = (m_n[i] % (int'(m_div[i]) + 1)) == 0;
            end else begin
                m_tick[i] = 0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            logic [NUM_CH-1:0] et;
            logic [NUM_CH-1:0] es;
            logic ets;
            logic ess;
            for (int i = 0; i < NUM_CH; i++) begin
                et[i] = m_tick[i];
                es[i] = m_sq(i);
            end
            ets = (int'(sel) < NUM_CH) ? et[sel[1:0]] : 1'b0;
            ess = (int'(sel) < NUM_CH) ? es[sel[1:0]] : 1'b0;
            chk("tick", tick, et);
            chk("square", square, es);
            chk("tick_sel", tick_sel, ets);
            chk("square_sel", square_sel, ess);
        end
    end

    initial begin
        int hits;
        for (int i = 0; i < NUM_CH; i++) begin
            m_div[i] = DEF; m_n[i] = 0; m_base[i] = 0; m_tick[i] = 0;
        end

        // Reset, default divisor 4 on channel 0
        rst = 0; en = 4'b0001; sel = 0;
        step(); step();
        chk_on = 1;
        chk("rst_tick", tick, 0);
        chk("rst_square", square, 0);
        rst = 1;
        for (int e = 1; e <= 15; e++) begin
            step();
            chk("t1_tick0", tick[0], (e % 5) == 0);
            chk("t1_sq0", square[0], ((e / 5) % 2) == 1);
        end
        chk("t1_tick_hi", tick[3:1], 0);

        // D = 0 on channel 2
        en = 4'b0101; wr_en = 1; wr_ch = 2; wr_div = 0; sel = 2;
        step();
        wr_en = 0;
        chk("t2_wr_tick", tick[2], 0);
        chk("t2_wr_sq", square[2], 0);
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("t2_tick2", tick[2], 1);
            chk("t2_sq2", square[2], k % 2);
        end

        // Rewrite channel 1 from D=4 at cnt=3 to D=2
        rst = 0; step(); rst = 1;
        en = 4'b0010; sel = 1;
        step(); step(); step();
        wr_en = 1; wr_ch = 1; wr_div = 2;
        step();
        wr_en = 0;
        chk("t3_wr_tick", tick[1], 0);
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("t3_tick1", tick[1], k == 3);
        end

        // Divisors 1..4, sync, ticks coincide after 60 edges
        en = 0;
        for (int c = 0; c < 4; c++) begin
            wr_en = 1; wr_ch = SEL_W'(c); wr_div = CNT_W'(c + 1);
            step();
        end
        wr_en = 0; en = 4'hF;
        for (int k = 0; k < 7; k++) step();
        sync = 1; step(); sync = 0;
        chk("t4_sync_tick", tick, 0);
        chk("t4_sync_sq", square, 0);
        hits = 0;
        for (int k = 1; k <= 60; k++) begin
            step();
            if (&tick) hits++;
            if (k == 60) chk("t4_all_60", tick, 4'hF);
        end
        chk("t4_hits", hits, 1);

        // sync beats write; out-of-range write ignored
        sync = 1; wr_en = 1; wr_ch = 0; wr_div = 9;
        step();
        sync = 0; wr_en = 0;
        step(); chk("t5_k1", tick[0], 0);
        step(); chk("t5_k2", tick[0], 1);
        wr_en = 1; wr_ch = 3'b111; wr_div = 0;
        step(); chk("t5_k3", tick[0], 0);
        wr_en = 0;
        step(); chk("t5_k4", tick[0], 1);

        // Mid-count reset, then pause channel 0
        en = 4'b0001; sel = 0;
        step();
        rst = 0; step(); rst = 1;
        chk("t6_rst_tick", tick, 0);
        chk("t6_rst_sq", square, 0);
        step(); step();
        en = 0;
        for (int k = 0; k < 7; k++) begin
            step();
            chk("t6_pause", tick[0], 0);
        end
        en = 4'b0001; sel = 5;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("t6_resume", tick[0], k == 3);
            chk("t6_sel5", tick_sel, 0);
        end

        // Maximum divisor on channel 3
        en = 4'b1000; sel = 3;
        wr_en = 1; wr_ch = 3; wr_div = 8'hFF;
        step();
        wr_en = 0;
        for (int k = 1; k <= 520; k++) begin
            step();
            if (k == 256) chk("t7_max_tick", tick[3], 1);
            if (k == 255) chk("t7_max_pre", tick[3], 0);
        end

        // Randomized traffic
        for (int k = 0; k < 4000; k++) begin
            rst    = ($urandom_range(0, 199) != 0);
            sync   = ($urandom_range(0, 49) == 0);
            wr_en  = ($urandom_range(0, 19) == 0);
            wr_ch  = SEL_W'($urandom_range(0, 7));
            case ($urandom_range(0, 9))
                0:       wr_div = 8'hFF;
                1:       wr_div = CNT_W'($urandom);
                default: wr_div = CNT_W'($urandom_range(0, 6));
            endcase
            for (int b = 0; b < NUM_CH; b++)
                en[b] = ($urandom_range(0, 4) != 0);
            sel = SEL_W'($urandom_range(0, 7));
            step();
        end

        @(posedge clk);
        chk_on = 0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
